// File: rtl/enc_round_core_if.sv
// Byte-stream handshake bundle for enc_round_core: plaintext/key in, ciphertext out.
interface enc_round_core_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] in_key;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/enc_round_core.sv
// Iterative 8-bit encryption core: ROUNDS rounds of key-mix, forward AES S-box
// and rotate-left-by-one, then a final key whitening.
// Optional feature: define ENC_CBC_EN to chain each block's input with the
// previous ciphertext (CBC); undefined gives independent blocks (ECB).
//
// state | meaning
// IDLE  | waiting for plaintext/key, in_ready high
// RUN   | one round per cycle, rnd counts 0..ROUNDS-1
// DONE  | ciphertext held on out_data until out_ready
module enc_round_core #(
  parameter int ROUNDS = 4
) (
  input logic             clk,
  input logic             rst_n,
  enc_round_core_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  localparam logic [7:0] FINAL_K  = 8'(ROUNDS);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t     state_q, state_d;
  logic [7:0] s_q, s_d;
  logic [7:0] rk_q, rk_d;
  logic [3:0] rnd_q, rnd_d;
  logic [7:0] out_q, out_d;
`ifdef ENC_CBC_EN
  logic [7:0] chain_q, chain_d;
`endif

  logic [7:0] sub;
  logic [7:0] s_round;
  logic [7:0] rk_rot;
  logic [3:0] rnd_inc;

  // Round datapath: the single S-box lookup shared by every round.
  always_comb begin
    sub     = SBOX[s_q ^ rk_q];
    s_round = {sub[6:0], sub[7]};
    rk_rot  = {rk_q[6:0], rk_q[7]};
    rnd_inc = rnd_q + 4'd1;
  end

  // Next-state and register updates for IDLE -> RUN -> DONE.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
`ifdef ENC_CBC_EN
    chain_d = chain_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef ENC_CBC_EN
          s_d = bus.in_data ^ chain_q;
`else
          s_d = bus.in_data;
`endif
          rk_d    = bus.in_key;
          rnd_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = s_round;
        rk_d  = rk_rot ^ {4'd0, rnd_inc};
        rnd_d = rnd_inc;
        if (rnd_q == LAST_RND) begin
          // Final whitening key equals the next round key, i.e. rotl1(rk) ^ ROUNDS.
          out_d   = s_round ^ rk_rot ^ FINAL_K;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
`ifdef ENC_CBC_EN
          chain_d = out_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 8'h00;
      rk_q    <= 8'h00;
      rnd_q   <= 4'd0;
      out_q   <= 8'h00;
`ifdef ENC_CBC_EN
      chain_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      out_q   <= out_d;
`ifdef ENC_CBC_EN
      chain_q <= chain_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_q;

endmodule
